time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper.sv | 168 ++++++++++++++++
 tb/tb_time_keeper.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// Time-of-day keeper: binary hh:mm:ss counted from a clock prescaler, with a
// set mode for manual field adjust, BCD display output, 12/24-hour display
// selection and a blink strobe for the field being adjusted.
module time_keeper #(
  parameter int TICK_DIV  = 100_000_000,
  parameter bit H24       = 1'b1,
  parameter int INIT_H    = 16,
  parameter int INIT_M    = 35,
  parameter int INIT_S    = 30,
  parameter int BLINK_DIV = TICK_DIV / 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        set_mode,
  input  logic        sel_btn,
  input  logic        up_btn,
  input  logic        dwn_btn,
  output logic [23:0] numbers,
  output logic [1:0]  field,
  output logic        pm,
  output logic        blink,
  output logic        sec_pulse
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    F_SEC = 2'd0,
    F_MIN = 2'd1,
    F_HR  = 2'd2
  } field_t;

  logic [4:0]    hours;
  logic [5:0]    minutes;
  logic [5:0]    seconds;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          blink_q;
  field_t        field_q;
  logic          sel_q, up_q, dwn_q;

  logic sel_press, up_press, dwn_press;
  logic adj_up, adj_dn, adj_press, tick;
  logic [5:0] hour_disp;

  // Step a value by one inside 0..top, wrapping at either end.
  function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                           input logic [5:0] top,
                                           input logic       inc);
    if (inc) return (v == top) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  // Two BCD digits (tens, units) of a 0..63 value.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // A press is a rising edge; up and down together cancel out.
  assign sel_press = sel_btn & ~sel_q;
  assign up_press  = up_btn  & ~up_q;
  assign dwn_press = dwn_btn & ~dwn_q;
  assign adj_up    = set_mode & up_press  & ~dwn_press;
  assign adj_dn    = set_mode & dwn_press & ~up_press;
  assign adj_press = set_mode & (up_press | dwn_press);
  assign tick      = ~set_mode & (presc == PRESC_MAX);

  // Button history registers, updated every cycle regardless of mode.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values.
    if (RST) begin
      sel_q <= 1'b0;
      up_q  <= 1'b0;
      dwn_q <= 1'b0;
    end else begin
      sel_q <= sel_btn;
      up_q  <= up_btn;
      dwn_q <= dwn_btn;
    end
  end

  // Prescaler: counts one second of clocks, frozen at zero in set mode.
  always_ff @(posedge CLK) begin
    if (RST || set_mode) begin
      presc     <= '0;
      sec_pulse <= 1'b0;
    end else if (presc == PRESC_MAX) begin
      presc     <= '0;
      sec_pulse <= 1'b1;
    end else begin
      presc     <= presc + PW'(1);
      sec_pulse <= 1'b0;
    end
  end

  // Time registers: one-second advance with carries, or single-field adjust.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hours   <= 5'(INIT_H);
      minutes <= 6'(INIT_M);
      seconds <= 6'(INIT_S);
    end else if (tick) begin
      if (seconds == 6'd59) begin
        seconds <= 6'd0;
        if (minutes == 6'd59) begin
          minutes <= 6'd0;
          hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end else begin
          minutes <= minutes + 6'd1;
        end
      end else begin
        seconds <= seconds + 6'd1;
      end
    end else if (adj_up || adj_dn) begin
      case (field_q)
        F_SEC:   seconds <= wrap_step(seconds, 6'd59, adj_up);
        F_MIN:   minutes <= wrap_step(minutes, 6'd59, adj_up);
        F_HR:    hours   <= 5'(wrap_step({1'b0, hours}, 6'd23, adj_up));
        default: ;
      endcase
    end
  end

  // Field selector rotates seconds -> minutes -> hours on sel in set mode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      field_q <= F_MIN;
    end else if (set_mode && sel_press) begin
      case (field_q)
        F_SEC:   field_q <= F_MIN;
        F_MIN:   field_q <= F_HR;
        default: field_q <= F_SEC;
      endcase
    end
  end

  // Blink generator: runs only in set mode, restarts visible on any adjust.
  always_ff @(posedge CLK) begin
    if (RST || !set_mode || adj_press) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Hour value as displayed, folded to 1..12 in 12-hour mode.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    hour_disp = {1'b0, hours};
    if (!H24) begin
      if (hours == 5'd0)       hour_disp = 6'd12;
      else if (hours > 5'd12)  hour_disp = {1'b0, hours} - 6'd12;
    end
  end

  assign numbers = {to_bcd(hour_disp), to_bcd(minutes), to_bcd(seconds)};
  assign pm      = (hours >= 5'd12);
  assign field   = field_q;
  assign blink   = blink_q | ~set_mode;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: two instances (24-hour and 12-hour display) share
// the same stimulus; a seconds-of-day model predicts every output each cycle,
// and directed steps pin the model with hand-computed literal values.
module tb_time_keeper;

  localparam int TICK = 4;
  localparam int BL   = 2;
  localparam int DAY  = 86400;
  localparam int INIT_TOD = 16 * 3600 + 35 * 60 + 30;

  logic CLK;
  logic rst, set_mode, sel_btn, up_btn, dwn_btn;
  logic [23:0] numbers_a, numbers_b;
  logic [1:0]  field_a, field_b;
  logic        pm_a, pm_b, blink_a, blink_b, pulse_a, pulse_b;

  int tests = 0;
  int fails = 0;

  time_keeper #(.TICK_DIV(TICK), .H24(1'b1), .BLINK_DIV(BL)) dut_a (
    .CLK(CLK), .RST(rst), .set_mode(set_mode), .sel_btn(sel_btn),
    .up_btn(up_btn), .dwn_btn(dwn_btn), .numbers(numbers_a), .field(field_a),
    .pm(pm_a), .blink(blink_a), .sec_pulse(pulse_a));

  time_keeper #(.TICK_DIV(TICK), .H24(1'b0), .BLINK_DIV(BL)) dut_b (
    .CLK(CLK), .RST(rst), .set_mode(set_mode), .sel_btn(sel_btn),
    .up_btn(up_btn), .dwn_btn(dwn_btn), .numbers(numbers_b), .field(field_b),
    .pm(pm_b), .blink(blink_b), .sec_pulse(pulse_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_tod, m_run, m_bage, m_field;
  logic m_pulse, m_valid = 1'b0;
  logic m_psel, m_pup, m_pdwn;

  function automatic logic [23:0] exp_numbers(input int tod, input bit h24);
    int h, mi, s;
    h  = tod / 3600;
    mi = (tod / 60) % 60;
    s  = tod % 60;
    if (!h24) h = (h % 12 == 0) ? 12 : h % 12;
    return 24'(((h / 10) << 20) | ((h % 10) << 16) | ((mi / 10) << 12) |
               ((mi % 10) << 8) | ((s / 10) << 4) | (s % 10));
  endfunction

  always @(posedge CLK) begin : model
    int tod, run, bage, fld, h, mi, s, d;
    logic pulse, sp, sel_p, up_p, dwn_p;
    tod = m_tod; run = m_run; bage = m_bage; fld = m_field; pulse = 1'b0;
    if (rst) begin
      tod = INIT_TOD; run = 0; bage = 0; fld = 1;
    end else begin
      sp    = set_mode;
      sel_p = sel_btn && !m_psel;
      up_p  = up_btn  && !m_pup;
      dwn_p = dwn_btn && !m_pdwn;
      if (!sp) begin
        run = run + 1;
        if (run % TICK == 0) begin
          tod   = (tod + 1) % DAY;
          pulse = 1'b1;
        end
      end else begin
        run = 0;
      end
      if (sp && (up_p != dwn_p)) begin
        h  = tod / 3600;
        mi = (tod / 60) % 60;
        s  = tod % 60;
        d  = up_p ? 1 : -1;
        case (fld)
          0: s  = (s + d + 60) % 60;
          1: mi = (mi + d + 60) % 60;
          default: h = (h + d + 24) % 24;
        endcase
        tod = h * 3600 + mi * 60 + s;
      end
      if (sp && sel_p) fld = (fld + 1) % 3;
      if (!sp || up_p || dwn_p) bage = 0;
      else bage = bage + 1;
    end
    m_tod   <= tod;
    m_run   <= run;
    m_bage  <= bage;
    m_field <= fld;
    m_pulse <= pulse;
    m_psel  <= rst ? 1'b0 : sel_btn;
    m_pup   <= rst ? 1'b0 : up_btn;
    m_pdwn  <= rst ? 1'b0 : dwn_btn;
    if (rst) m_valid <= 1'b1;
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("numbers_24h", numbers_a, exp_numbers(m_tod, 1'b1));
      check("numbers_12h", numbers_b, exp_numbers(m_tod, 1'b0));
      check("field_24h", field_a, m_field);
      check("field_12h", field_b, m_field);
      check("pm_24h", pm_a, (m_tod / 3600) >= 12);
      check("pm_12h", pm_b, (m_tod / 3600) >= 12);
      check("blink_24h", blink_a, !set_mode || ((m_bage / BL) % 2 == 0));
      check("blink_12h", blink_b, !set_mode || ((m_bage / BL) % 2 == 0));
      check("sec_pulse_24h", pulse_a, m_pulse);
      check("sec_pulse_12h", pulse_b, m_pulse);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic sm, input logic s, input logic u, input logic d);
    set_mode = sm; sel_btn = s; up_btn = u; dwn_btn = d;
    @(posedge CLK);
    #2;
  endtask

  task automatic press(input logic s, input logic u, input logic d);
    step(1'b1, s, u, d);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; set_mode = 1'b0; sel_btn = 1'b0; up_btn = 1'b0; dwn_btn = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("reset_numbers", numbers_a, 24'h163530);
    check("reset_field", field_a, 2'd1);
    check("reset_blink", blink_a, 1'b1);
    check("reset_pulse", pulse_a, 1'b0);
    check("reset_pm", pm_a, 1'b1);
    rst = 1'b0;

    // First second after reset lands on the fourth edge.
    repeat (3) step(0, 0, 0, 0);
    check("pre_second_numbers", numbers_a, 24'h163530);
    check("pre_second_pulse", pulse_a, 1'b0);
    step(0, 0, 0, 0);
    check("first_second_numbers", numbers_a, 24'h163531);
    check("first_second_pulse", pulse_a, 1'b1);
    step(0, 0, 0, 0);
    check("pulse_one_cycle", pulse_a, 1'b0);

    // Preload 23:59:59 through the adjust buttons.
    step(1, 0, 0, 0);
    repeat (24) press(0, 1, 0);
    press(1, 0, 0);
    repeat (7) press(0, 1, 0);
    press(1, 0, 0);
    repeat (32) press(0, 0, 1);
    check("preload_numbers", numbers_a, 24'h235959);
    check("preload_field", field_a, 2'd0);
    repeat (3) step(0, 0, 0, 0);
    check("before_midnight", numbers_a, 24'h235959);
    step(0, 0, 0, 0);
    check("midnight_numbers", numbers_a, 24'h000000);
    check("midnight_pm", pm_a, 1'b0);

    // Hour field wraps 0 -> 23 on down, other fields untouched.
    step(1, 0, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check("field_hours", field_a, 2'd2);
    check("h12_hour0_digits", numbers_b, 24'h120000);
    check("h12_hour0_pm", pm_b, 1'b0);
    press(0, 0, 1);
    check("hour_borrowless_wrap", numbers_a, 24'h230000);
    repeat (11) press(0, 0, 1);
    check("h12_hour12_digits", numbers_b, 24'h120000);
    check("h12_hour12_pm", pm_b, 1'b1);
    press(0, 1, 0);
    check("h12_hour13_digits", numbers_b, 24'h010000);
    check("h12_hour13_pm", pm_b, 1'b1);

    // Up and down together cancel; a held button counts once.
    press(0, 1, 1);
    check("up_dwn_cancel", numbers_a, 24'h130000);
    repeat (10) step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    check("held_up_once", numbers_a, 24'h140000);

    // Select and up together: adjust lands on the old field.
    press(1, 1, 0);
    check("sel_up_old_field", numbers_a, 24'h150000);
    check("sel_up_new_field", field_a, 2'd0);

    // Reset wins over an adjust press in set mode.
    rst = 1'b1;
    step(1, 0, 1, 0);
    check("rst_mid_adjust_numbers", numbers_a, 24'h163530);
    check("rst_mid_adjust_field", field_a, 2'd1);
    check("rst_mid_adjust_pulse", pulse_a, 1'b0);
    rst = 1'b0;

    // Reset wins over the prescaler wrap.
    repeat (3) step(0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);
    check("rst_on_wrap_numbers", numbers_a, 24'h163530);
    check("rst_on_wrap_pulse", pulse_a, 1'b0);
    rst = 1'b0;

    // Randomized run checked cycle by cycle against the model.
    begin
      logic sm = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 39) == 0) sm = ~sm;
        rst = ($urandom_range(0, 499) == 0);
        step(sm, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0);
      end
      rst = 1'b0;
      step(0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
